// File: rtl/clk_div_gen_pkg.sv
// Shared types and constants for the divided-clock generator.
package clk_div_gen_pkg;

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int unsigned NCH_DEF      = 4;
  localparam int unsigned DIVW_DEF     = 5;
  localparam int unsigned LOCK_CNT_DEF = 20;
  localparam int unsigned DIVW_MAX     = 16;
  localparam int unsigned RATIO_W      = DIVW_MAX + 2;

  // Channel period in CLKVCO cycles: (2 + div), doubled in slow mode.
  function automatic logic [RATIO_W-1:0] ratio(input logic [DIVW_MAX-1:0] div,
                                               input logic                slow);
    logic [RATIO_W-1:0] base;
    base = RATIO_W'(div) + RATIO_W'(2);
    return slow ? (base << 1) : base;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divided-clock channel: period counter plus registered CLKOUT/CLKEN.
module clk_div_chan
  import clk_div_gen_pkg::*;
#(
  parameter int unsigned DIVW = DIVW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic [DIVW-1:0] div_i,
  input  logic            slow_i,
  output logic            clkout_o,
  output logic            clken_o
);

  localparam int unsigned CW = DIVW + 2;

  logic [CW-1:0] ratio_c;
  logic [CW-1:0] high_c;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          clkout_q;
  logic          clken_q;

  assign ratio_c = CW'(ratio(DIVW_MAX'(div_i), slow_i));
  // High phase is the larger half when the period is odd.
  assign high_c  = (ratio_c + CW'(1)) >> 1;
  assign cnt_d   = (cnt_q >= ratio_c - CW'(1)) ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      clkout_q <= 1'b0;
      clken_q  <= 1'b0;
    end else if (clr_i) begin
      cnt_q    <= '0;
      clkout_q <= 1'b0;
      clken_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      clkout_q <= (cnt_q < high_c);
      clken_q  <= (cnt_q == '0);
    end
  end

  assign clkout_o = clkout_q;
  assign clken_o  = clken_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider with config handshake, power-down and lock detect.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter int unsigned NCH      = NCH_DEF,
  parameter int unsigned DIVW     = DIVW_DEF,
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
  input  logic                CLKVCO,
  input  logic                RSTB,
  input  logic                PD,
  input  logic                CFG_VLD,
  output logic                CFG_RDY,
  input  logic [NCH*DIVW-1:0] CFG_DIV,
  input  logic [NCH-1:0]      CFG_SLOW,
  output logic [NCH-1:0]      CLKOUT,
  output logic [NCH-1:0]      CLKEN,
  output logic                LKDET
);

  localparam int unsigned SW = 8;

  state_e                state_q;
  state_e                state_d;
  logic [SW-1:0]         scnt_q;
  logic [SW-1:0]         scnt_d;
  logic [NCH*DIVW-1:0]   div_q;
  logic [NCH-1:0]        slow_q;
  logic                  rdy_q;
  logic                  lkdet_q;
  logic                  hs_c;
  logic                  clr_c;
  logic [NCH-1:0]        clkout_q;
  logic [NCH-1:0]        clken_q;

  assign hs_c  = CFG_VLD & rdy_q;
  assign clr_c = (state_d == ST_STOP);

  always_ff @(posedge CLKVCO or negedge RSTB) begin
    if (!RSTB) begin
      state_q <= ST_SETTLE;
      scnt_q  <= '0;
      div_q   <= '0;
      slow_q  <= '0;
      rdy_q   <= 1'b0;
      lkdet_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      if (hs_c) begin
        div_q  <= CFG_DIV;
        slow_q <= CFG_SLOW;
      end
      rdy_q   <= (state_d != ST_STOP);
      lkdet_q <= (state_d == ST_RUN);
    end
  end

  // Settle count includes the STOP cycle, so lock lands LOCK_CNT cycles after the common phase.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    case (state_q)
      ST_STOP: begin
        if (PD) begin
          scnt_d = '0;
        end else begin
          state_d = ST_SETTLE;
          scnt_d  = SW'(1);
        end
      end
      ST_SETTLE: begin
        if (PD || hs_c) begin
          state_d = ST_STOP;
          scnt_d  = '0;
        end else if (scnt_q >= SW'(LOCK_CNT)) begin
          state_d = ST_RUN;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      ST_RUN: begin
        if (PD || hs_c) begin
          state_d = ST_STOP;
          scnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_STOP;
        scnt_d  = '0;
      end
    endcase
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(
      .DIVW(DIVW)
    ) u_chan (
      .clk     (CLKVCO),
      .rst_n   (RSTB),
      .clr_i   (clr_c),
      .div_i   (div_q[i*DIVW +: DIVW]),
      .slow_i  (slow_q[i]),
      .clkout_o(clkout_q[i]),
      .clken_o (clken_q[i])
    );
  end

  assign CLKOUT  = clkout_q | {NCH{PD}};
  assign CLKEN   = clken_q;
  assign LKDET   = lkdet_q;
  assign CFG_RDY = rdy_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: phase-origin model checked every cycle, plus directed literals.
module tb_clk_div_gen;

  localparam int unsigned NCH  = 4;
  localparam int unsigned DIVW = 5;
  localparam int unsigned L    = 20;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic                pd    = 1'b0;
  logic                vld   = 1'b0;
  logic                rdy;
  logic [NCH*DIVW-1:0] div   = '0;
  logic [NCH-1:0]      slow  = '0;
  logic [NCH-1:0]      clkout;
  logic [NCH-1:0]      clken;
  logic                lkdet;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: cycle index, first cycle of the common phase, first locked cycle, active config.
  int cyc     = 0;
  int t0      = 1;
  int lock_at = 1 + L;
  int m_div [NCH];
  int m_slow[NCH];

  always #5 clk = ~clk;

  clk_div_gen #(
    .NCH     (NCH),
    .DIVW    (DIVW),
    .LOCK_CNT(L)
  ) dut (
    .CLKVCO  (clk),
    .RSTB    (rst_n),
    .PD      (pd),
    .CFG_VLD (vld),
    .CFG_RDY (rdy),
    .CFG_DIV (div),
    .CFG_SLOW(slow),
    .CLKOUT  (clkout),
    .CLKEN   (clken),
    .LKDET   (lkdet)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // Advance the model at each rising edge using the inputs the DUT samples.
  always @(posedge clk) begin
    int  cur;
    logic rdy_m;
    logic hs;
    if (!rst_n) begin
      cyc     = 0;
      t0      = 1;
      lock_at = 1 + L;
      for (int i = 0; i < NCH; i++) begin
        m_div[i]  = 0;
        m_slow[i] = 0;
      end
    end else begin
      cur   = cyc;
      rdy_m = (cur >= t0);
      hs    = vld && rdy_m;
      if (hs) begin
        for (int i = 0; i < NCH; i++) begin
          m_div[i]  = int'(div[i*DIVW +: DIVW]);
          m_slow[i] = int'(slow[i]);
        end
      end
      if (hs || pd) begin
        t0      = cur + 2;
        lock_at = cur + 2 + L;
      end
      cyc = cur + 1;
    end
  end

  always @(negedge clk) begin
    logic [NCH-1:0] eo;
    logic [NCH-1:0] ee;
    logic           el;
    logic           er;
    int             p;
    int             r;
    int             m;
    eo = '0;
    ee = '0;
    el = 1'b0;
    er = 1'b0;
    if (rst_n && cyc >= t0) begin
      p = cyc - t0;
      for (int i = 0; i < NCH; i++) begin
        r     = (2 + m_div[i]) * ((m_slow[i] != 0) ? 2 : 1);
        m     = p % r;
        eo[i] = (m < (r + 1) / 2);
        ee[i] = (m == 0);
      end
      el = (cyc >= lock_at);
      er = 1'b1;
    end
    eo = eo | {NCH{pd}};
    check("m_clkout", 32'(clkout), 32'(eo));
    check("m_clken",  32'(clken),  32'(ee));
    check("m_lkdet",  32'(lkdet),  32'(el));
    check("m_rdy",    32'(rdy),    32'(er));
  end

  // Land just after the falling edge of model cycle n.
  task automatic at_cyc(input int n);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (cyc < n && g < 5000);
    #1;
    if (cyc != n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL at_cyc wanted=%0d got=%0d", n, cyc);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int pd_left;
    pd_left = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_clkout", 32'(clkout), 32'h0);
    check("rst_clken",  32'(clken),  32'h0);
    check("rst_lkdet",  32'(lkdet),  32'h0);
    check("rst_rdy",    32'(rdy),    32'h0);
    rst_n = 1'b1;

    at_cyc(1);
    check("first_clkout", 32'(clkout), 32'hF);
    check("first_clken",  32'(clken),  32'hF);
    check("first_rdy",    32'(rdy),    32'h1);
    at_cyc(2);
    check("r2_clkout", 32'(clkout), 32'h0);
    at_cyc(20);
    check("rst_lock_pre", 32'(lkdet), 32'h0);
    at_cyc(21);
    check("rst_lock", 32'(lkdet), 32'h1);

    // Ratios 2,3,5,32 from a common edge.
    at_cyc(30);
    vld  = 1'b1;
    div  = {5'd30, 5'd3, 5'd1, 5'd0};
    slow = 4'b0000;
    at_cyc(31);
    vld  = 1'b0;
    div  = 20'($urandom());
    slow = 4'($urandom());
    check("stop_clkout", 32'(clkout), 32'h0);
    check("stop_rdy",    32'(rdy),    32'h0);
    at_cyc(32);
    check("align_clkout", 32'(clkout), 32'hF);
    check("align_clken",  32'(clken),  32'hF);
    at_cyc(33);
    check("p1_clkout", 32'(clkout), 32'hE);
    at_cyc(51);
    check("cfg_lock_pre", 32'(lkdet), 32'h0);
    at_cyc(52);
    check("cfg_lock", 32'(lkdet), 32'h1);

    // Slow mode on channel 2 only.
    at_cyc(60);
    vld  = 1'b1;
    div  = {5'd30, 5'd3, 5'd1, 5'd0};
    slow = 4'b0100;
    at_cyc(61);
    vld  = 1'b0;
    slow = 4'($urandom());
    at_cyc(66);
    check("slow_hi", 32'(clkout[2]), 32'h1);
    at_cyc(67);
    check("slow_lo", 32'(clkout[2]), 32'h0);
    at_cyc(72);
    check("slow_wrap", 32'(clkout[2]), 32'h1);

    // Reconfigure during SETTLE restarts lock count.
    at_cyc(100);
    vld  = 1'b1;
    div  = {5'd7, 5'd6, 5'd5, 5'd4};
    slow = 4'b0000;
    at_cyc(101);
    vld = 1'b0;
    at_cyc(110);
    vld = 1'b1;
    div = '0;
    at_cyc(111);
    vld = 1'b0;
    div = 20'($urandom());
    check("resettle_rdy", 32'(rdy), 32'h0);
    at_cyc(122);
    check("resettle_nolock", 32'(lkdet), 32'h0);
    at_cyc(131);
    check("resettle_lock_pre", 32'(lkdet), 32'h0);
    at_cyc(132);
    check("resettle_lock", 32'(lkdet), 32'h1);

    // Power-down for 7 cycles in RUN.
    at_cyc(140);
    pd = 1'b1;
    at_cyc(142);
    check("pd_clkout", 32'(clkout), 32'hF);
    check("pd_lkdet",  32'(lkdet),  32'h0);
    check("pd_rdy",    32'(rdy),    32'h0);
    at_cyc(147);
    pd = 1'b0;
    at_cyc(148);
    check("pd_resume_clken", 32'(clken), 32'hF);
    at_cyc(167);
    check("pd_lock_pre", 32'(lkdet), 32'h0);
    at_cyc(168);
    check("pd_lock", 32'(lkdet), 32'h1);

    // Power-down and handshake together: config still latched.
    at_cyc(180);
    pd   = 1'b1;
    vld  = 1'b1;
    div  = {5'd2, 5'd2, 5'd2, 5'd2};
    slow = 4'b0000;
    at_cyc(181);
    pd  = 1'b0;
    vld = 1'b0;
    at_cyc(182);
    check("pdcfg_align", 32'(clkout), 32'hF);
    at_cyc(184);
    check("pdcfg_ratio4", 32'(clkout), 32'h0);

    for (int c = 200; c < 1700; c++) begin
      at_cyc(c);
      if (pd_left > 0) pd_left--;
      else if ($urandom_range(0, 49) == 0) pd_left = $urandom_range(1, 8);
      pd   = (pd_left > 0);
      vld  = ($urandom_range(0, 9) == 0);
      div  = 20'($urandom());
      slow = 4'($urandom());
    end

    at_cyc(1700);
    pd  = 1'b0;
    vld = 1'b0;
    at_cyc(1705);
    vld  = 1'b1;
    div  = {5'd30, 5'd30, 5'd30, 5'd30};
    slow = 4'b0000;
    at_cyc(1706);
    vld = 1'b0;
    at_cyc(1722);
    check("d30_hi", 32'(clkout), 32'hF);
    at_cyc(1723);
    check("d30_lo", 32'(clkout), 32'h0);
    at_cyc(1740);
    check("d30_lock", 32'(lkdet), 32'h1);

    // Asynchronous reset mid-RUN.
    rst_n = 1'b0;
    #1;
    check("async_clkout", 32'(clkout), 32'h0);
    check("async_lkdet",  32'(lkdet),  32'h0);
    check("async_rdy",    32'(rdy),    32'h0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    at_cyc(1);
    check("rerst_first", 32'(clkout), 32'hF);
    at_cyc(2);
    check("rerst_ratio2", 32'(clkout), 32'h0);
    at_cyc(3);
    check("rerst_ratio2b", 32'(clkout), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter NCH, default 4: number of divided-clock channels (1..8).
REQ-002 Parameter DIVW, default 5: width of each per-channel divide code.
REQ-003 Parameter LOCK_CNT, default 20: settle cycles before lock is reported (1..255).
REQ-004 CLKVCO  input  1  sole clock; all flops on rising edge.
REQ-005 RSTB  input  1  reset, asynchronous assert, active-low.
REQ-006 PD  input  1  power-down; forces all CLKOUT high.
REQ-007 CFG_VLD  input  1  new configuration offered.
REQ-008 CFG_RDY  output  1  configuration can be accepted this cycle.
REQ-009 CFG_DIV  input  NCH*DIVW  divide codes; channel i at bits [i*DIVW +: DIVW].
REQ-010 CFG_SLOW  input  NCH  per-channel half-rate (memory slow mode) select.
REQ-011 CLKOUT  output  NCH  divided clocks, registered.
REQ-012 CLKEN  output  NCH  one-cycle pulse coincident with each CLKOUT rising cycle.
REQ-013 LKDET  output  1  high when outputs are stable and phase-aligned.

Function
REQ-014 Channel ratio SHALL be R = (2 + DIV) * (SLOW ? 2 : 1) CLKVCO cycles; counter width DIVW+2, no overflow for any code.
REQ-015 CLKOUT SHALL be high for ceil(R/2) cycles, then low for floor(R/2) cycles, starting high at count 0.
REQ-016 CLKEN[i] SHALL be 1 exactly in the cycle where channel i's count is 0, otherwise 0.
REQ-017 FSM states SHALL be STOP, SETTLE, RUN.
REQ-018 STOP: counters held at 0, CLKOUT=0, CLKEN=0, LKDET=0, CFG_RDY=0; exits to SETTLE next cycle unless PD=1.
REQ-019 SETTLE: channels run from active config; settle counter increments each cycle; LKDET=0, CFG_RDY=1; after LOCK_CNT cycles -> RUN.
REQ-020 RUN: channels run; LKDET=1, CFG_RDY=1.
REQ-021 Handshake CFG_VLD&CFG_RDY in SETTLE or RUN SHALL latch CFG_DIV/CFG_SLOW into the active config and enter STOP next cycle.
REQ-022 Config accepted at cycle t: STOP at t+1; at t+2 all CLKOUT=1 and all CLKEN=1 (common phase); LKDET=1 at t+2+LOCK_CNT.
REQ-023 Config accepted during SETTLE SHALL restart the settle count from zero via STOP.
REQ-024 Config inputs SHALL be ignored when no handshake occurs; active config never changes otherwise.
REQ-025 PD=1 SHALL force CLKOUT to all-ones combinationally, CLKEN=0, LKDET=0, and move FSM to STOP; held there while PD=1.
REQ-026 PD falling SHALL resume via SETTLE with the current active config, same alignment as REQ-022.
REQ-027 PD and CFG handshake in the same cycle: config SHALL be latched, PD behaviour applies.

Reset
REQ-028 RSTB low SHALL asynchronously clear: state=SETTLE, settle count=0, all active DIV=0, SLOW=0, channel counters=0.
REQ-029 Reset outputs: CLKOUT=0, CLKEN=0, LKDET=0, CFG_RDY=0; first cycle after release CLKOUT=1, CLKEN=1, CFG_RDY=1.
REQ-030 Reset mid-SETTLE or mid-RUN SHALL discard the latched config and return to REQ-028 values.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, default parameter constants and the ratio function of REQ-014.
REQ-032 One sub-module clk_div_chan (counter + CLKOUT/CLKEN flops, inputs: clear, DIV, SLOW) SHALL be instantiated NCH times.
REQ-033 No latches, no gated clocks; only the PD OR on CLKOUT is combinational on outputs.

Verification
REQ-034 Reset release, no config -> all CLKOUT toggle every cycle (R=2), LKDET rises 21 cycles after first edge.
REQ-035 Config DIV={0,1,3,30}, SLOW=0 at t -> STOP at t+1, CLKOUT periods 2,3,5,32 from t+2 with common rising edge, LKDET at t+22.
REQ-036 DIV=3 with SLOW=1 on channel 2 only -> channel 2 period 10 (5 high/5 low), others unchanged.
REQ-037 Second config at t+10 during SETTLE -> STOP at t+11, LKDET stays 0 until t+32.
REQ-038 PD high for 7 cycles in RUN -> CLKOUT all 1, LKDET 0, CFG_RDY 0; after PD low, aligned restart, LKDET 20 cycles later.
REQ-039 RSTB asserted mid-RUN with DIV=30 -> outputs clear immediately; post-release ratio returns to 2.
